pll_lock_ctrl: RTL and testbench

- Supervises the DDS clock PLL: issues the PLL reset pulse, waits for lock with a timeout, and requires lock to stay stable before releasing the downstream DDS reset.
- Retries on failure, detects loss of lock at run time, and reports status.
- Runs on the free-running 50 MHz reference clock that also feeds the PLL refclk.
- Sits between the board reset and the PLL `rst`/`locked` pins and the DDS datapath reset.

---
 rtl/pll_lock_ctrl.sv | 170 +++++++++++++++++
 tb/tb_pll_lock_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_ctrl.sv
// pll_lock_ctrl: PLL reset/lock supervisor gating the DDS datapath reset.
// Rev 1.0
`timescale 1ns / 1ps
`default_nettype none

module pll_lock_ctrl #(
  parameter int unsigned RST_PULSE_CYC    = 16,
  parameter int unsigned LOCK_TIMEOUT_CYC = 50000,
  parameter int unsigned LOCK_STABLE_CYC  = 1024,
  parameter int unsigned MAX_RETRY        = 3,
  parameter int unsigned CNT_W            = 16
) (
  input  logic       refclk_i,
  input  logic       rst_ni,
  input  logic       en_i,
  input  logic       relock_req_i,
  input  logic       pll_locked_i,
  output logic       pll_rst_o,
  output logic       dds_rst_no,
  output logic       ready_o,
  output logic       fail_o,
  output logic [1:0] retry_cnt_o,
  output logic [7:0] lol_cnt_o
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_PLL_RST   = 3'd1,
    S_WAIT_LOCK = 3'd2,
    S_STABLE    = 3'd3,
    S_RUN       = 3'd4,
    S_FAIL      = 3'd5
  } state_e;

  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYC - 1);
  localparam logic [1:0]       RETRY_LAST   = 2'(MAX_RETRY - 1);
  localparam logic [1:0]       RETRY_MAX    = 2'(MAX_RETRY);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       retry_q, retry_d;
  logic [7:0]       lol_q, lol_d;
  logic             sync1_q, locked_s_q;
  logic             pll_rst_q, dds_rst_n_q, ready_q, fail_q;
  logic             attempt_failed;

  always_ff @(posedge refclk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q    <= 1'b0;
      locked_s_q <= 1'b0;
    end else begin
      sync1_q    <= pll_locked_i;
      locked_s_q <= sync1_q;
    end
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    retry_d        = retry_q;
    lol_d          = lol_q;
    attempt_failed = 1'b0;

    if (!en_i) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_PLL_RST;
          cnt_d   = '0;
          retry_d = 2'd0;
        end
        S_PLL_RST: begin
          if (cnt_q == RST_LAST) begin
            state_d = S_WAIT_LOCK;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_WAIT_LOCK: begin
          if (locked_s_q) begin
            state_d = S_STABLE;
            cnt_d   = '0;
          end else if (cnt_q == TIMEOUT_LAST) begin
            attempt_failed = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_STABLE: begin
          // Any dropout restarts the whole stability window via a retry.
          if (!locked_s_q) begin
            attempt_failed = 1'b1;
          end else if (cnt_q == STABLE_LAST) begin
            state_d = S_RUN;
            cnt_d   = '0;
            retry_d = 2'd0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_RUN: begin
          if (!locked_s_q) begin
            if (lol_q != 8'hFF) lol_d = lol_q + 8'd1;
            state_d = S_PLL_RST;
            cnt_d   = '0;
          end else if (relock_req_i) begin
            state_d = S_PLL_RST;
            cnt_d   = '0;
          end
        end
        S_FAIL: begin
          state_d = S_FAIL;
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase

      if (attempt_failed) begin
        cnt_d = '0;
        if (retry_q == RETRY_LAST) begin
          state_d = S_FAIL;
          retry_d = RETRY_MAX;
        end else begin
          state_d = S_PLL_RST;
          retry_d = retry_q + 2'd1;
        end
      end
    end
  end

  // Status flops decode the next state so they match the state register each cycle.
  always_ff @(posedge refclk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      retry_q     <= 2'd0;
      lol_q       <= 8'd0;
      pll_rst_q   <= 1'b1;
      dds_rst_n_q <= 1'b0;
      ready_q     <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      lol_q       <= lol_d;
      pll_rst_q   <= (state_d == S_IDLE) || (state_d == S_PLL_RST) || (state_d == S_FAIL);
      dds_rst_n_q <= (state_d == S_RUN);
      ready_q     <= (state_d == S_RUN);
      fail_q      <= (state_d == S_FAIL);
    end
  end

  assign pll_rst_o   = pll_rst_q;
  assign dds_rst_no  = dds_rst_n_q;
  assign ready_o     = ready_q;
  assign fail_o      = fail_q;
  assign retry_cnt_o = retry_q;
  assign lol_cnt_o   = lol_q;

endmodule

`default_nettype wire

// File: tb/tb_pll_lock_ctrl.sv
// tb_pll_lock_ctrl: directed vector table plus randomized run against a phase/elapsed-time model.
// Rev 1.0
`timescale 1ns / 1ps
`default_nettype none

module tb_pll_lock_ctrl;
  localparam int RP = 4;
  localparam int TO = 20;
  localparam int ST = 8;
  localparam int MR = 3;

  localparam int P_IDLE = 0, P_PRST = 1, P_WAIT = 2, P_STAB = 3, P_RUN = 4, P_FAIL = 5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       en = 1'b0;
  logic       relock = 1'b0;
  logic       pin = 1'b0;
  logic       pll_rst, dds_rst_n, ready, fail;
  logic [1:0] retry_cnt;
  logic [7:0] lol_cnt;
  logic [13:0] dut_out;

  pll_lock_ctrl #(
    .RST_PULSE_CYC(RP), .LOCK_TIMEOUT_CYC(TO), .LOCK_STABLE_CYC(ST),
    .MAX_RETRY(MR), .CNT_W(16)
  ) dut (
    .refclk_i(clk), .rst_ni(rst_n), .en_i(en), .relock_req_i(relock),
    .pll_locked_i(pin), .pll_rst_o(pll_rst), .dds_rst_no(dds_rst_n),
    .ready_o(ready), .fail_o(fail), .retry_cnt_o(retry_cnt), .lol_cnt_o(lol_cnt)
  );

  assign dut_out = {pll_rst, dds_rst_n, ready, fail, retry_cnt, lol_cnt};

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  function automatic void check(input string name, input logic [13:0] act, input logic [13:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h required %h", name, act, exp);
  endfunction

  // Reference model: phase + cycles elapsed in phase + 2-deep lock history.
  int   m_ph, m_el, m_retry, m_lol;
  logic m_s1, m_s2;

  function automatic void m_reset();
    m_ph = P_IDLE; m_el = 0; m_retry = 0; m_lol = 0; m_s1 = 1'b0; m_s2 = 1'b0;
  endfunction

  function automatic void m_attempt_failed();
    m_retry++;
    m_el = 0;
    if (m_retry == MR) m_ph = P_FAIL;
    else m_ph = P_PRST;
  endfunction

  function automatic void model_step();
    logic ls;
    if (!rst_n) begin
      m_reset();
      return;
    end
    ls   = m_s2;
    m_s2 = m_s1;
    m_s1 = pin;
    if (!en) begin
      m_ph = P_IDLE;
      m_el = 0;
    end else begin
      case (m_ph)
        P_IDLE: begin m_ph = P_PRST; m_el = 0; m_retry = 0; end
        P_PRST: begin
          m_el++;
          if (m_el == RP) begin m_ph = P_WAIT; m_el = 0; end
        end
        P_WAIT: begin
          if (ls) begin m_ph = P_STAB; m_el = 0; end
          else begin
            m_el++;
            if (m_el == TO) m_attempt_failed();
          end
        end
        P_STAB: begin
          if (!ls) m_attempt_failed();
          else begin
            m_el++;
            if (m_el == ST) begin m_ph = P_RUN; m_el = 0; m_retry = 0; end
          end
        end
        P_RUN: begin
          if (!ls) begin
            if (m_lol < 255) m_lol++;
            m_ph = P_PRST; m_el = 0;
          end else if (relock) begin
            m_ph = P_PRST; m_el = 0;
          end
        end
        default: ;
      endcase
    end
  endfunction

  function automatic logic [13:0] m_out();
    logic prst;
    prst = (m_ph == P_IDLE) || (m_ph == P_PRST) || (m_ph == P_FAIL);
    return {prst, m_ph == P_RUN, m_ph == P_RUN, m_ph == P_FAIL, 2'(m_retry), 8'(m_lol)};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    cyc++;
    #1;
    check($sformatf("model@%0d", cyc), dut_out, m_out());
  endtask

  typedef struct {
    logic       en, relock, lock;
    int         n;
    logic [13:0] exp;   // {pll_rst, dds_rst_n, ready, fail, retry[1:0], lol[7:0]}
    string      tag;
  } vec_t;

  function automatic vec_t mk(input string tag, input logic e, input logic r, input logic l, input int n,
                              input logic pr, input logic dr, input logic rd, input logic fl,
                              input logic [1:0] rc, input logic [7:0] lc);
    vec_t v;
    v.tag = tag; v.en = e; v.relock = r; v.lock = l; v.n = n;
    v.exp = {pr, dr, rd, fl, rc, lc};
    return v;
  endfunction

  localparam logic [13:0] RESET_VAL = {1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0};

  vec_t tbl[$];
  bit   healthy;

  initial begin
    m_reset();
    tbl.push_back(mk("idle",        0,0,0, 2,  1,0,0,0, 0,0));
    tbl.push_back(mk("rst_pulse",   1,0,0, 4,  1,0,0,0, 0,0));
    tbl.push_back(mk("rst_fall",    1,0,0, 1,  0,0,0,0, 0,0));
    tbl.push_back(mk("wait5",       1,0,0, 4,  0,0,0,0, 0,0));
    tbl.push_back(mk("stable_pre",  1,0,1, 10, 0,0,0,0, 0,0));
    tbl.push_back(mk("run",         1,0,1, 1,  0,1,1,0, 0,0));
    tbl.push_back(mk("relock",      1,1,1, 1,  1,0,0,0, 0,0));
    tbl.push_back(mk("relock_seq",  1,0,1, 12, 0,0,0,0, 0,0));
    tbl.push_back(mk("run2",        1,0,1, 1,  0,1,1,0, 0,0));
    tbl.push_back(mk("lol_edge1",   1,0,0, 1,  0,1,1,0, 0,0));
    tbl.push_back(mk("lol_edge2",   1,0,1, 1,  0,1,1,0, 0,0));
    tbl.push_back(mk("lol_edge3",   1,0,1, 1,  1,0,0,0, 0,1));
    tbl.push_back(mk("lol_seq",     1,0,1, 12, 0,0,0,0, 0,1));
    tbl.push_back(mk("run3",        1,0,1, 1,  0,1,1,0, 0,1));
    tbl.push_back(mk("both_edge1",  1,0,0, 1,  0,1,1,0, 0,1));
    tbl.push_back(mk("both_edge2",  1,0,1, 1,  0,1,1,0, 0,1));
    tbl.push_back(mk("both_edge3",  1,1,1, 1,  1,0,0,0, 0,2));
    tbl.push_back(mk("both_seq",    1,0,1, 12, 0,0,0,0, 0,2));
    tbl.push_back(mk("run4",        1,0,1, 1,  0,1,1,0, 0,2));
    tbl.push_back(mk("en_off",      0,0,0, 1,  1,0,0,0, 0,2));
    tbl.push_back(mk("flap_wait",   1,0,0, 5,  0,0,0,0, 0,2));
    tbl.push_back(mk("flap_hi",     1,0,1, 5,  0,0,0,0, 0,2));
    tbl.push_back(mk("flap_lo",     1,0,0, 2,  0,0,0,0, 0,2));
    tbl.push_back(mk("flap_retry",  1,0,0, 1,  1,0,0,0, 1,2));
    tbl.push_back(mk("pulse1",      1,0,0, 3,  1,0,0,0, 1,2));
    tbl.push_back(mk("wait_a",      1,0,0, 1,  0,0,0,0, 1,2));
    tbl.push_back(mk("wait_a19",    1,0,0, 19, 0,0,0,0, 1,2));
    tbl.push_back(mk("timeout2",    1,0,0, 1,  1,0,0,0, 2,2));
    tbl.push_back(mk("pulse2",      1,0,0, 3,  1,0,0,0, 2,2));
    tbl.push_back(mk("wait_b",      1,0,0, 1,  0,0,0,0, 2,2));
    tbl.push_back(mk("wait_b19",    1,0,0, 19, 0,0,0,0, 2,2));
    tbl.push_back(mk("fail",        1,0,0, 1,  1,0,0,1, 3,2));
    tbl.push_back(mk("fail_hold",   1,1,1, 5,  1,0,0,1, 3,2));
    tbl.push_back(mk("fail_exit",   0,0,1, 1,  1,0,0,0, 3,2));
    tbl.push_back(mk("restart",     1,0,1, 1,  1,0,0,0, 0,2));
    tbl.push_back(mk("mid_stable",  1,0,1, 6,  0,0,0,0, 0,2));

    #1 rst_n = 1'b0;
    #1 check("reset_async", dut_out, RESET_VAL);
    tick();
    tick();
    #1 rst_n = 1'b1;

    foreach (tbl[i]) begin
      en = tbl[i].en; relock = tbl[i].relock; pin = tbl[i].lock;
      for (int k = 0; k < tbl[i].n; k++) tick();
      check(tbl[i].tag, dut_out, tbl[i].exp);
    end
    relock = 1'b0;

    // Reset in STABLE must take effect before the next refclk edge.
    #2 rst_n = 1'b0;
    #1 check("rst_mid_stable", dut_out, RESET_VAL);
    m_reset();
    tick();
    check("rst_held", dut_out, RESET_VAL);
    rst_n = 1'b1;

    healthy = 1'b1;
    en = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      tick();
      if (!rst_n) rst_n = 1'b1;
      if (en) en = ($urandom_range(0, 299) != 0);
      else    en = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 149) == 0) healthy = ~healthy;
      pin    = healthy ^ ($urandom_range(0, 40) == 0);
      relock = ($urandom_range(0, 30) == 0);
      if ($urandom_range(0, 699) == 0) begin
        #2 rst_n = 1'b0;
        m_reset();
        #1 check("rand_async_rst", dut_out, m_out());
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
